// File: rtl/rf_access_arbiter.sv
// Two-client round-robin sequencer in front of a small register file.
// Each accepted request becomes one IDLE->ACCESS pair; reads return one cycle after the grant.
module rf_access_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [ADDR_W-1:0] rf_r_addr,
  output logic [DATA_W-1:0] rf_w_data,
  input  logic [DATA_W-1:0] rf_r_data
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic                win_q, win_d;
  logic                last_q, last_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvld_q, rvld_d;
  logic                rwin_q, rwin_d;
  logic                pick;

  // On a tie the client that was not granted last wins.
  always_comb begin
    if (req0 && req1) pick = ~last_q;
    else              pick = req1;
  end

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    rvld_d  = 1'b0;
    rwin_d  = rwin_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = ACCESS;
          win_d   = pick;
          last_d  = pick;
          we_d    = pick ? we1    : we0;
          addr_d  = pick ? addr1  : addr0;
          wdata_d = pick ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_d = IDLE;
        if (!we_q) begin
          rdata_d = rf_r_data;
          rvld_d  = 1'b1;
          rwin_d  = win_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      win_q   <= 1'b0;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      rvld_q  <= 1'b0;
      rwin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      rvld_q  <= rvld_d;
      rwin_q  <= rwin_d;
    end
  end

  // Grants and the write strobe are gated by rst_n so a reset landing in ACCESS aborts the access.
  assign gnt0      = rst_n && (state_q == ACCESS) && !win_q;
  assign gnt1      = rst_n && (state_q == ACCESS) &&  win_q;
  assign rf_wr_en  = rst_n && (state_q == ACCESS) &&  we_q;
  assign rvalid0   = rvld_q && !rwin_q;
  assign rvalid1   = rvld_q &&  rwin_q;
  assign rdata     = rdata_q;
  assign rf_w_addr = addr_q;
  assign rf_r_addr = addr_q;
  assign rf_w_data = wdata_q;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Directed bench for rf_access_arbiter with a behavioural 4x8 register file attached.
module tb_rf_access_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [1:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0] rdata;
  logic       rf_wr_en;
  logic [1:0] rf_w_addr, rf_r_addr;
  logic [7:0] rf_w_data, rf_r_data;

  logic [7:0] mem [4];
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rf_wr_en) mem[rf_w_addr] <= rf_w_data;
  end
  assign rf_r_data = mem[rf_r_addr];

  rf_access_arbiter #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .rf_wr_en(rf_wr_en), .rf_w_addr(rf_w_addr),
    .rf_r_addr(rf_r_addr), .rf_w_data(rf_w_data), .rf_r_data(rf_r_data)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int c, input logic we, input logic [1:0] a, input logic [7:0] d);
    if (c == 0) begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
    else        begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
  endtask

  task automatic drop_req(input int c);
    if (c == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  task automatic do_write(input int c, input logic [1:0] a, input logic [7:0] d);
    set_req(c, 1'b1, a, d);
    tick();
    chk("wr_gnt", (c == 0) ? gnt0 : gnt1, 1);
    chk("wr_en", rf_wr_en, 1);
    drop_req(c);
    tick();
  endtask

  task automatic do_read(input int c, input logic [1:0] a, input logic [7:0] exp);
    set_req(c, 1'b0, a, 8'h00);
    tick();
    chk("rd_gnt", (c == 0) ? gnt0 : gnt1, 1);
    chk("rd_addr", rf_r_addr, a);
    drop_req(c);
    tick();
    chk("rd_rvalid", (c == 0) ? rvalid0 : rvalid1, 1);
    chk("rd_rvalid_other", (c == 0) ? rvalid1 : rvalid0, 0);
    chk("rd_rdata", rdata, exp);
  endtask

  initial begin
    int prev;
    int g;
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 2'd3; addr1 = 2'd2; wdata0 = 8'hEE; wdata1 = 8'hDD;

    // Reset held with both requests asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_gnt0", gnt0, 0);
      chk("rst_gnt1", gnt1, 0);
      chk("rst_rvalid0", rvalid0, 0);
      chk("rst_rvalid1", rvalid1, 0);
      chk("rst_wr_en", rf_wr_en, 0);
      chk("rst_w_addr", rf_w_addr, 0);
      chk("rst_r_addr", rf_r_addr, 0);
      chk("rst_w_data", rf_w_data, 0);
      chk("rst_rdata", rdata, 0);
    end
    req0 = 1'b0; req1 = 1'b0;
    rst_n = 1'b1;
    tick();
    chk("idle_gnt0", gnt0, 0);

    // Single write then read
    set_req(0, 1'b1, 2'd2, 8'hA5);
    tick();
    chk("t2_gnt0", gnt0, 1);
    chk("t2_gnt1", gnt1, 0);
    chk("t2_wr_en", rf_wr_en, 1);
    chk("t2_w_addr", rf_w_addr, 2);
    chk("t2_w_data", rf_w_data, 8'hA5);
    drop_req(0);
    tick();
    chk("t2_gnt0_off", gnt0, 0);
    chk("t2_wr_en_off", rf_wr_en, 0);
    chk("t2_w_addr_hold", rf_w_addr, 2);
    do_read(0, 2'd2, 8'hA5);
    tick();
    chk("t2_rvalid0_pulse", rvalid0, 0);
    chk("t2_rdata_hold", rdata, 8'hA5);

    do_write(0, 2'd1, 8'h11);
    do_write(0, 2'd3, 8'h33);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t3_rst_rdata", rdata, 0);

    // Simultaneous reads right after reset: client 0 first
    set_req(0, 1'b0, 2'd1, 8'h00);
    set_req(1, 1'b0, 2'd3, 8'h00);
    tick();
    chk("t3_gnt0", gnt0, 1);
    chk("t3_gnt1_a", gnt1, 0);
    drop_req(0);
    tick();
    chk("t3_rvalid0", rvalid0, 1);
    chk("t3_rdata0", rdata, 8'h11);
    chk("t3_gnt1_b", gnt1, 0);
    tick();
    chk("t3_gnt1", gnt1, 1);
    chk("t3_rvalid0_off", rvalid0, 0);
    drop_req(1);
    tick();
    chk("t3_rvalid1", rvalid1, 1);
    chk("t3_rvalid0_c", rvalid0, 0);
    chk("t3_rdata1", rdata, 8'h33);

    // Fairness: both hold requests for 8 grants
    set_req(0, 1'b0, 2'd2, 8'h00);
    set_req(1, 1'b0, 2'd2, 8'h00);
    prev = 1;
    g = 0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i % 2 == 1) begin
        chk("t4_gnt0", gnt0, (prev == 1) ? 1 : 0);
        chk("t4_gnt1", gnt1, (prev == 0) ? 1 : 0);
        prev = gnt1 ? 1 : 0;
        g++;
      end else begin
        chk("t4_idle_gnt", {gnt0, gnt1}, 0);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("t4_grants", g, 8);
    tick();
    do_write(0, 2'd1, 8'h77);

    // Write/read hazard: client 1 wins, client 0 sees the new value
    set_req(1, 1'b1, 2'd0, 8'h5C);
    set_req(0, 1'b0, 2'd0, 8'h00);
    tick();
    chk("t5_gnt1", gnt1, 1);
    chk("t5_gnt0", gnt0, 0);
    chk("t5_wr_en", rf_wr_en, 1);
    chk("t5_w_data", rf_w_data, 8'h5C);
    drop_req(1);
    tick();
    chk("t5_idle", {gnt0, gnt1}, 0);
    tick();
    chk("t5_gnt0_b", gnt0, 1);
    chk("t5_r_addr", rf_r_addr, 0);
    drop_req(0);
    tick();
    chk("t5_rvalid0", rvalid0, 1);
    chk("t5_rdata", rdata, 8'h5C);

    // Reset during ACCESS aborts the write
    do_write(1, 2'd3, 8'h00);
    set_req(0, 1'b1, 2'd3, 8'hFF);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_wr_en", rf_wr_en, 0);
    chk("t6_gnt0", gnt0, 0);
    drop_req(0);
    tick();
    chk("t6_rst_gnt", {gnt0, gnt1}, 0);
    chk("t6_rst_rvalid", {rvalid0, rvalid1}, 0);
    rst_n = 1'b1;
    tick();
    chk("t6_post_gnt", {gnt0, gnt1}, 0);
    chk("t6_post_rvalid", {rvalid0, rvalid1}, 0);
    chk("t6_post_wr_en", rf_wr_en, 0);
    do_read(0, 2'd3, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_access_arbiter.md
Name: rf_access_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one 4-entry x 8-bit register file between two requesting clients (client 0, client 1).
- Serialises requests into single register-file accesses. Drives the register file's wr_en / w_addr / r_addr / w_data ports and returns registered read data with a valid pulse.
- Sits between the client logic and the reg_file instance. It is the only driver of the reg_file ports.

Parameters:
- DATA_W, 8, register-file data width
- ADDR_W, 2, register-file address width (2**ADDR_W entries)

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst_n  in  1  synchronous active-low reset
- req0 / req1  in  1  client request; held until gnt of same client seen
- we0 / we1  in  1  1 = write, 0 = read; stable while req high
- addr0 / addr1  in  ADDR_W  access address; stable while req high
- wdata0 / wdata1  in  DATA_W  write data; stable while req high
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted and performed
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata holds read result for that client
- rdata  out  DATA_W  registered read data, shared by both clients
- rf_wr_en  out  1  to reg_file wr_en
- rf_w_addr  out  ADDR_W  to reg_file w_addr
- rf_r_addr  out  ADDR_W  to reg_file r_addr
- rf_w_data  out  DATA_W  to reg_file w_data
- rf_r_data  in  DATA_W  from reg_file r_data; combinational on rf_r_addr

Behaviour:
- FSM states: IDLE, ACCESS.
- IDLE:
  - If no req, stay in IDLE.
  - Otherwise pick a winner, latch winner index, we, addr and wdata into internal registers, and go to ACCESS.
- ACCESS:
  - rf_w_addr = rf_r_addr = latched addr; rf_w_data = latched wdata.
  - rf_wr_en = rst_n & latched we.
  - gnt of the winner = 1 for exactly this cycle.
  - If read: capture rf_r_data into rdata at the end of this cycle.
  - Always return to IDLE.
- Read path: rvalid of the winner pulses high for one cycle, the cycle after ACCESS, with rdata valid in that cycle. rdata holds its value until the next read capture.
- Latency:
  - req sampled in IDLE -> gnt in the next cycle -> rvalid in the cycle after that (reads only).
  - Throughput is one access per 2 cycles.
- Write visibility: reg_file writes at the clock edge ending ACCESS, so a read granted next is guaranteed to see the new value.
- Arbitration:
  - Single request: that client wins.
  - Both requesting: the client not granted last wins.
  - last_gnt pointer updates on entry to ACCESS.
  - Reset value of last_gnt = 1, so client 0 wins the first tie.
- Handshake:
  - A client drops or changes req at the edge ending its gnt cycle.
  - A req still high in the following IDLE cycle is treated as a new request.
  - Inputs of a non-granted client are ignored and must stay stable.
- Outside ACCESS: rf_wr_en = 0 and both gnt = 0; rf_* address/data outputs keep their last latched values.
- Reset (rst_n low at a clock edge), all registers cleared:
  - state = IDLE, last_gnt = 1, latched addr/data/we = 0, rdata = 0, pending-rvalid = 0.
  - So gnt0/1 = 0, rvalid0/1 = 0, rf_wr_en = 0, rf_w_addr = rf_r_addr = 0, rf_w_data = 0.
- Reset mid-operation:
  - rst_n low during ACCESS forces rf_wr_en = 0 in that cycle (gated), so no reg_file write occurs.
  - Any pending rvalid is cancelled; no gnt or rvalid is issued after reset.
- Address wrap: addresses are ADDR_W bits; no range check is needed.

Test Plan:
1. Reset: hold rst_n = 0 for 3 cycles with req0 = req1 = 1 -> gnt0/1, rvalid0/1, rf_wr_en, rf addresses and rdata are all 0 throughout.
2. Single write then read: client 0 writes 0xA5 to addr 2 -> gnt0 pulses with rf_wr_en = 1, rf_w_addr = 2, rf_w_data = 0xA5. Client 0 then reads addr 2 -> rvalid0 pulses 1 cycle after gnt0 with rdata = 0xA5.
3. Simultaneous reads after reset: entries 1 = 0x11 and 3 = 0x33 preloaded; req0 reads addr 1 and req1 reads addr 3 in the same cycle.
   - Order is gnt0, rvalid0 (rdata = 0x11), then gnt1, rvalid1 (rdata = 0x33).
   - The two grants are 2 cycles apart.
4. Fairness: both clients hold req continuously for 8 grants -> grants alternate 0,1,0,1,… with no client granted twice in a row.
5. Write-then-read hazard:
   - Client 1 writes 0x5C to addr 0 while client 0 requests a read of addr 0 in the same cycle; client 0 was granted last, so client 1 wins.
   - Client 1's write is granted first; client 0's read returns rdata = 0x5C.
6. Reset mid-access: client 0 writes 0xFF to addr 3 (entry previously 0x00) and rst_n is driven low in its ACCESS cycle.
   - rf_wr_en = 0 in that cycle and no gnt0 is seen.
   - After reset, reading addr 3 returns 0x00.
